// File: rtl/i2c_master_cmd_ctrl.sv
// Transaction front-end for i2c_master: latches one request, buffers TX/RX bytes in
// show-ahead FIFOs, sequences start/transfer and reports completion status to the host.
module i2c_master_cmd_ctrl #(
  parameter int G_FIFO_DEPTH     = 16,
  parameter int G_TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       i_rw,
  input  logic [6:0] i_chip_addr,
  input  logic [7:0] i_nb_data,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_full,
  output logic [7:0] o_rx_data,
  input  logic       i_rx_ack,
  output logic       o_rx_empty,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_err,
  output logic       o_start,
  output logic       o_rw,
  output logic [6:0] o_chip_addr,
  output logic [7:0] o_nb_data,
  output logic [7:0] o_wdata,
  input  logic [7:0] i_rdata,
  input  logic       i_rdata_valid,
  input  logic       i_next_wdata_rdy,
  input  logic       i_sack_error
);
  localparam int AW = $clog2(G_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(G_TIMEOUT_CYCLES) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(G_FIFO_DEPTH);
  localparam logic [8:0]    DEPTH_9 = 9'(G_FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(G_TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_XFER   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]    state_r, state_nxt_s;
  logic [1:0]    err_nxt_s;
  logic [7:0]    tx_mem_r [G_FIFO_DEPTH];
  logic [7:0]    rx_mem_r [G_FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [LW-1:0] tx_level_r, rx_level_r, tx_disc_s;
  logic [7:0]    cnt_r, cnt_inc_s;
  logic [TW-1:0] to_cnt_r;
  logic [8:0]    tx_rem_s;
  logic          prog_s, to_hit_s, invalid_s, ready_s, rx_full_s;
  logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  assign o_tx_full  = (tx_level_r == DEPTH_L);
  assign rx_full_s  = (rx_level_r == DEPTH_L);
  assign o_rx_empty = (rx_level_r == {LW{1'b0}});
  assign o_wdata    = tx_mem_r[tx_rd_ptr_r];
  assign o_rx_data  = rx_mem_r[rx_rd_ptr_r];

  assign prog_s    = (state_r == S_XFER) && (o_rw ? i_rdata_valid : i_next_wdata_rdy);
  assign cnt_inc_s = cnt_r + {7'd0, prog_s};
  assign to_hit_s  = (to_cnt_r == TO_LAST);
  assign invalid_s = (o_nb_data == 8'd0) || ({1'b0, o_nb_data} > DEPTH_9);
  assign ready_s   = o_rw ? ((DEPTH_9 - 9'(rx_level_r)) >= {1'b0, o_nb_data})
                          : (9'(tx_level_r) >= {1'b0, o_nb_data});

  assign tx_pop_s  = (state_r == S_XFER) && !o_rw && i_next_wdata_rdy && (tx_level_r != {LW{1'b0}});
  assign tx_push_s = i_tx_valid && (!o_tx_full || tx_pop_s);
  assign rx_pop_s  = i_rx_ack && !o_rx_empty;
  assign rx_push_s = (state_r == S_XFER) && o_rw && i_rdata_valid && (!rx_full_s || rx_pop_s);
  assign tx_rem_s  = {1'b0, o_nb_data} - {1'b0, cnt_r};

  // Drop the unsent bytes of a failed write so the next request starts on its own data
  always_comb begin
    tx_disc_s = {LW{1'b0}};
    if ((state_r == S_FINISH) && !o_rw && (o_err != 2'b00)) begin
      if (tx_rem_s > 9'(tx_level_r)) begin
        tx_disc_s = tx_level_r;
      end else begin
        tx_disc_s = tx_rem_s[LW-1:0];
      end
    end else begin
      tx_disc_s = {LW{1'b0}};
    end
  end

  // Next-state and completion-code decode
  always_comb begin
    state_nxt_s = state_r;
    err_nxt_s   = 2'b00;
    case (state_r)
      S_IDLE: begin
        if (i_req) state_nxt_s = S_CHECK;
        else       state_nxt_s = S_IDLE;
      end
      S_CHECK: begin
        if (invalid_s) begin
          state_nxt_s = S_FINISH;
          err_nxt_s   = 2'b11;
        end else if (ready_s) begin
          state_nxt_s = S_LAUNCH;
        end else if (to_hit_s) begin
          state_nxt_s = S_FINISH;
          err_nxt_s   = 2'b10;
        end else begin
          state_nxt_s = S_CHECK;
        end
      end
      S_LAUNCH: state_nxt_s = S_XFER;
      S_XFER: begin
        // sack error wins over a count completing in the same cycle
        if (i_sack_error) begin
          state_nxt_s = S_FINISH;
          err_nxt_s   = 2'b01;
        end else if (cnt_inc_s == o_nb_data) begin
          state_nxt_s = S_FINISH;
        end else if (to_hit_s && !prog_s) begin
          state_nxt_s = S_FINISH;
          err_nxt_s   = 2'b10;
        end else begin
          state_nxt_s = S_XFER;
        end
      end
      S_FINISH: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Control FSM, request registers, byte and timeout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 2'b00;
      o_start     <= 1'b0;
      o_rw        <= 1'b0;
      o_chip_addr <= 7'd0;
      o_nb_data   <= 8'd0;
      cnt_r       <= 8'd0;
      to_cnt_r    <= {TW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      o_start <= (state_nxt_s == S_LAUNCH);
      o_done  <= (state_nxt_s == S_FINISH);
      o_err   <= (state_nxt_s == S_FINISH) ? err_nxt_s : 2'b00;
      if ((state_r == S_IDLE) && i_req) begin
        o_rw        <= i_rw;
        o_chip_addr <= i_chip_addr;
        o_nb_data   <= i_nb_data;
        o_busy      <= 1'b1;
      end else if (state_nxt_s == S_FINISH) begin
        o_busy <= 1'b0;
      end
      if ((state_r == S_IDLE) || (state_r == S_LAUNCH)) begin
        cnt_r <= 8'd0;
      end else if (state_r == S_XFER) begin
        cnt_r <= cnt_inc_s;
      end
      if (((state_r == S_CHECK) || (state_r == S_XFER)) && (state_nxt_s == state_r)) begin
        to_cnt_r <= prog_s ? {TW{1'b0}} : (to_cnt_r + TW'(1'b1));
      end else begin
        to_cnt_r <= {TW{1'b0}};
      end
    end
  end

  // TX FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < G_FIFO_DEPTH; i++) tx_mem_r[i] <= 8'd0;
      tx_wr_ptr_r <= {AW{1'b0}};
      tx_rd_ptr_r <= {AW{1'b0}};
      tx_level_r  <= {LW{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r] <= i_tx_data;
        tx_wr_ptr_r           <= tx_wr_ptr_r + AW'(1'b1);
      end
      tx_rd_ptr_r <= tx_rd_ptr_r + AW'(tx_pop_s) + tx_disc_s[AW-1:0];
      tx_level_r  <= tx_level_r + LW'(tx_push_s) - LW'(tx_pop_s) - tx_disc_s;
    end
  end

  // RX FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < G_FIFO_DEPTH; i++) rx_mem_r[i] <= 8'd0;
      rx_wr_ptr_r <= {AW{1'b0}};
      rx_rd_ptr_r <= {AW{1'b0}};
      rx_level_r  <= {LW{1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_ptr_r] <= i_rdata;
        rx_wr_ptr_r           <= rx_wr_ptr_r + AW'(1'b1);
      end
      rx_rd_ptr_r <= rx_rd_ptr_r + AW'(rx_pop_s);
      rx_level_r  <= rx_level_r + LW'(rx_push_s) - LW'(rx_pop_s);
    end
  end
endmodule

// File: tb/tb_i2c_master_cmd_ctrl.sv
// Directed self-checking bench for i2c_master_cmd_ctrl with a behavioural i2c_master stand-in.
module tb_i2c_master_cmd_ctrl;
  localparam int D  = 16;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_req, i_rw, i_tx_valid, i_rx_ack, i_rdata_valid, i_next_wdata_rdy, i_sack_error;
  logic [6:0] i_chip_addr;
  logic [7:0] i_nb_data, i_tx_data, i_rdata;
  logic       o_tx_full, o_rx_empty, o_busy, o_done, o_start, o_rw;
  logic [7:0] o_rx_data, o_nb_data, o_wdata;
  logic [6:0] o_chip_addr;
  logic [1:0] o_err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  logic [7:0] exp_q [$];

  i2c_master_cmd_ctrl #(.G_FIFO_DEPTH(D), .G_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_rw(i_rw), .i_chip_addr(i_chip_addr),
    .i_nb_data(i_nb_data), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_full(o_tx_full),
    .o_rx_data(o_rx_data), .i_rx_ack(i_rx_ack), .o_rx_empty(o_rx_empty), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_start(o_start), .o_rw(o_rw), .o_chip_addr(o_chip_addr),
    .o_nb_data(o_nb_data), .o_wdata(o_wdata), .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .i_next_wdata_rdy(i_next_wdata_rdy), .i_sack_error(i_sack_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_start) start_cnt++;
    if (o_done)  done_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    i_tx_valid = 1'b1;
    i_tx_data  = d;
    @(posedge clk); #1;
    i_tx_valid = 1'b0;
  endtask

  task automatic send_req(input logic rw, input logic [6:0] addr, input logic [7:0] nb);
    i_req = 1'b1; i_rw = rw; i_chip_addr = addr; i_nb_data = nb;
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    int n = 0;
    while (!o_start && n < 50) begin
      @(posedge clk); #1; n++;
    end
    seen = o_start;
  endtask

  task automatic wait_done(output int n, output bit seen);
    n = 0;
    while (!o_done && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    seen = o_done;
  endtask

  task automatic slave_write(input int nb);
    logic [7:0] e;
    for (int i = 0; i < nb; i++) begin
      repeat (2) @(posedge clk);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check_val("wdata", 32'(o_wdata), 32'(e));
      i_next_wdata_rdy = 1'b1;
      @(posedge clk); #1;
      i_next_wdata_rdy = 1'b0;
    end
  endtask

  task automatic slave_read(input int nb, input logic [7:0] base);
    for (int i = 0; i < nb; i++) begin
      repeat (2) @(posedge clk);
      #1;
      i_rdata = base + 8'(i);
      i_rdata_valid = 1'b1;
      @(posedge clk); #1;
      i_rdata_valid = 1'b0;
    end
  endtask

  task automatic do_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] nb,
                         input logic [6:0] slave_addr, input logic [1:0] exp_err, input logic [7:0] rd_base);
    bit seen;
    int n;
    send_req(rw, addr, nb);
    wait_start(seen);
    check_val("start_seen", 32'(seen), 32'd1);
    // a request while busy must not disturb the latched command
    i_req = 1'b1; i_chip_addr = 7'h7F; i_nb_data = 8'd9; i_rw = ~rw;
    @(posedge clk); #1;
    i_req = 1'b0;
    check_val("busy", 32'(o_busy), 32'd1);
    check_val("hold_addr", 32'(o_chip_addr), 32'(addr));
    check_val("hold_nb", 32'(o_nb_data), 32'(nb));
    check_val("hold_rw", 32'(o_rw), 32'(rw));
    if (slave_addr != addr) begin
      repeat (2) @(posedge clk);
      #1;
      i_sack_error = 1'b1;
      @(posedge clk); #1;
      i_sack_error = 1'b0;
    end else if (rw) begin
      slave_read(int'(nb), rd_base);
    end else begin
      slave_write(int'(nb));
    end
    wait_done(n, seen);
    check_val("done_seen", 32'(seen), 32'd1);
    check_val("err", 32'(o_err), 32'(exp_err));
    check_val("busy_at_done", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(o_done), 32'd0);
  endtask

  initial begin
    int s0, d0, n;
    bit seen;
    rst_n = 1'b0; i_req = 1'b0; i_rw = 1'b0; i_chip_addr = 7'd0; i_nb_data = 8'd0;
    i_tx_data = 8'd0; i_tx_valid = 1'b0; i_rx_ack = 1'b0; i_rdata = 8'd0; i_rdata_valid = 1'b0;
    i_next_wdata_rdy = 1'b0; i_sack_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_done", 32'(o_done), 32'd0);
    check_val("rst_start", 32'(o_start), 32'd0);
    check_val("rst_err", 32'(o_err), 32'd0);
    check_val("rst_tx_full", 32'(o_tx_full), 32'd0);
    check_val("rst_rx_empty", 32'(o_rx_empty), 32'd1);
    check_val("rst_rx_data", 32'(o_rx_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write 3 bytes
    s0 = start_cnt;
    push_tx(8'hA5); push_tx(8'h5A); push_tx(8'hFF);
    exp_q = '{8'hA5, 8'h5A, 8'hFF};
    do_xfer(1'b0, 7'h50, 8'd3, 7'h50, 2'b00, 8'h00);
    check_val("wr3_starts", 32'(start_cnt - s0), 32'd1);

    // read 4 bytes, drain RX in order
    do_xfer(1'b1, 7'h50, 8'd4, 7'h50, 2'b00, 8'h01);
    for (int i = 0; i < 4; i++) begin
      check_val("rx_data", 32'(o_rx_data), 32'(i + 1));
      i_rx_ack = 1'b1;
      @(posedge clk); #1;
      i_rx_ack = 1'b0;
    end
    check_val("rx_empty_after", 32'(o_rx_empty), 32'd1);

    // NACK: unsent bytes discarded, next write sees only its own byte
    push_tx(8'h11); push_tx(8'h22);
    do_xfer(1'b0, 7'h50, 8'd2, 7'h51, 2'b01, 8'h00);
    push_tx(8'h33);
    exp_q = '{8'h33};
    do_xfer(1'b0, 7'h50, 8'd1, 7'h50, 2'b00, 8'h00);

    // invalid byte counts
    s0 = start_cnt;
    send_req(1'b0, 7'h50, 8'd0);
    wait_done(n, seen);
    check_val("inv0_done", 32'(seen), 32'd1);
    check_val("inv0_err", 32'(o_err), 32'd3);
    @(posedge clk); #1;
    send_req(1'b1, 7'h50, 8'(D + 1));
    wait_done(n, seen);
    check_val("inv17_done", 32'(seen), 32'd1);
    check_val("inv17_err", 32'(o_err), 32'd3);
    check_val("inv_no_start", 32'(start_cnt - s0), 32'd0);
    @(posedge clk); #1;

    // timeout waiting for TX data
    s0 = start_cnt;
    push_tx(8'h44); push_tx(8'h55);
    send_req(1'b0, 7'h50, 8'd4);
    wait_done(n, seen);
    check_val("to_done", 32'(seen), 32'd1);
    check_val("to_cycles", 32'(n), 32'(TO));
    check_val("to_err", 32'(o_err), 32'd2);
    check_val("to_no_start", 32'(start_cnt - s0), 32'd0);
    @(posedge clk); #1;
    push_tx(8'h66);
    exp_q = '{8'h66};
    do_xfer(1'b0, 7'h50, 8'd1, 7'h50, 2'b00, 8'h00);

    // full TX FIFO: extra push dropped, all 16 bytes sent in order
    for (int i = 0; i < D; i++) push_tx(8'h80 + 8'(i));
    check_val("tx_full", 32'(o_tx_full), 32'd1);
    push_tx(8'hEE);
    check_val("tx_full_drop", 32'(o_tx_full), 32'd1);
    exp_q = {};
    for (int i = 0; i < D; i++) exp_q.push_back(8'h80 + 8'(i));
    do_xfer(1'b0, 7'h50, 8'(D), 7'h50, 2'b00, 8'h00);
    check_val("tx_not_full", 32'(o_tx_full), 32'd0);

    // reset during XFER
    send_req(1'b1, 7'h50, 8'd2);
    wait_start(seen);
    check_val("rst_xfer_start", 32'(seen), 32'd1);
    slave_read(1, 8'h09);
    check_val("rx_has_byte", 32'(o_rx_empty), 32'd0);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(o_busy), 32'd0);
    check_val("mid_rst_rx_empty", 32'(o_rx_empty), 32'd1);
    check_val("mid_rst_start", 32'(o_start), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    push_tx(8'h77);
    exp_q = '{8'h77};
    do_xfer(1'b0, 7'h50, 8'd1, 7'h50, 2'b00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
